// File: rtl/binary_to_bcd_seq.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3) with valid/ready handshakes.
// Define BCD_OVF_EN to build the sticky overflow detector; otherwise ovf is tied 0.
module binary_to_bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic                  busy
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                r_state;
  logic [BIN_W-1:0]      r_bin;
  logic [4*DIGITS-1:0]   r_bcd;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_out_valid;
  logic                  r_busy;

  logic [4*DIGITS-1:0]       w_adj;
  logic [4*DIGITS+BIN_W-1:0] w_shift;
  logic                      w_accept;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ? r_bcd[4*gi +: 4] + 4'd3
                                                           : r_bcd[4*gi +: 4];
    end
  endgenerate

  // The top digit's MSB drops out here; it is only observed by the overflow logic.
  assign w_shift  = {w_adj[4*DIGITS-2:0], r_bin, 1'b0};

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign bcd_out   = r_bcd;

`ifdef BCD_OVF_EN
  logic r_ovf;
  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef BCD_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_SHIFT: begin
          r_bcd <= w_shift[4*DIGITS+BIN_W-1:BIN_W];
          r_bin <= w_shift[BIN_W-1:0];
          r_cnt <= r_cnt - CNT_W'(1);
`ifdef BCD_OVF_EN
          r_ovf <= r_ovf | w_adj[4*DIGITS-1];
`endif
          if (r_cnt == CNT_W'(1)) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready && !in_valid) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase

      // Accept can happen from IDLE or from DONE (back-to-back); it overrides the above.
      if (w_accept) begin
        r_state     <= S_SHIFT;
        r_bin       <= bin_in;
        r_bcd       <= '0;
        r_cnt       <= CNT_W'(BIN_W);
        r_out_valid <= 1'b0;
        r_busy      <= 1'b1;
`ifdef BCD_OVF_EN
        r_ovf       <= 1'b0;
`endif
      end
    end
  end

endmodule
